serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 16 +
 rtl/serial_subtractor.sv | 79 +++++++
 tb/tb_serial_subtractor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done operand and result bundle for the serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell and a borrow flip-flop
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  sub_io
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic             d_bit, br_nx, last;
    logic [WIDTH-1:0] res_nx;

    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        // result bit enters at the MSB; the concat keeps this legal for WIDTH=1
        res_nx  = WIDTH'({d_bit, res_q} >> 1);
        last    = cnt_q == CW'(WIDTH - 1);
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        if (state_q == IDLE && sub_io.start) begin
            state_d = RUN;
            a_d     = sub_io.a;
            b_d     = sub_io.b;
            br_d    = sub_io.bin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            br_d    = br_nx;
            res_d   = res_nx;
            cnt_d   = cnt_q + CW'(1);
            state_d = last ? DONE : RUN;
            diff_d  = last ? res_nx : diff_q;
            bout_d  = last ? br_nx : bout_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign sub_io.busy = state_q != IDLE;
    assign sub_io.done = state_q == DONE;
    assign sub_io.diff = diff_q;
    assign sub_io.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_subtractor_if #(.WIDTH(W)) sub ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .sub_io(sub.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(bin);
        return W'(r);
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        return int'(a) < int'(b) + int'(bin);
    endfunction

    // one accepted operation, timed from the accept edge
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int cyc;
        int busy_n;
        @(negedge clk);
        sub.start = 1'b1;
        sub.a     = a;
        sub.b     = b;
        sub.bin   = bin;
        @(negedge clk);
        sub.start = 1'b0;
        sub.a     = ~a;
        sub.b     = ~b;
        cyc       = 1;
        busy_n    = 0;
        while (!sub.done && cyc < 40) begin
            if (sub.busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        if (sub.busy) busy_n++;
        chk("latency", cyc, W + 1);
        chk("busy_cycles", busy_n, W + 1);
        chk("diff", sub.diff, ref_diff(a, b, bin));
        chk("bout", sub.bout, ref_bout(a, b, bin));
        @(negedge clk);
        chk("idle_after", {sub.busy, sub.done}, 2'b00);
    endtask

    initial begin
        int dones;
        int first;
        int second;
        logic [W-1:0] ra, rb;
        logic rbin;
        sub.start = 1'b0;
        sub.a     = '0;
        sub.b     = '0;
        sub.bin   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {sub.busy, sub.done, sub.bout, sub.diff}, '0);

        run_op(8'h5A, 8'h3C, 1'b0);
        chk("basic_diff", sub.diff, 8'h1E);
        run_op(8'h00, 8'h01, 1'b0);
        chk("underflow", {sub.bout, sub.diff}, 9'h1FF);
        run_op(8'h10, 8'h10, 1'b1);
        chk("borrow_in", {sub.bout, sub.diff}, 9'h1FF);
        run_op(8'h10, 8'h10, 1'b0);
        chk("equal", {sub.bout, sub.diff}, 9'h000);

        // start pulses on RUN cycle 3 and on the DONE cycle must be ignored
        @(negedge clk);
        sub.start = 1'b1; sub.a = 8'h5A; sub.b = 8'h3C; sub.bin = 1'b0;
        dones = 0; first = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (sub.done) begin
                dones++;
                if (first == 0) first = c;
            end
            sub.start = (c == 3 || c == 9);
            if (sub.start) begin sub.a = 8'h00; sub.b = 8'h01; sub.bin = 1'b1; end
        end
        chk("ignore_dones", dones, 1);
        chk("ignore_first", first, W + 1);
        chk("ignore_result", {sub.bout, sub.diff}, 9'h01E);
        chk("ignore_idle", sub.busy, 1'b0);

        // held start: next accept on the edge after the DONE cycle
        @(negedge clk);
        sub.start = 1'b1; sub.a = 8'h5A; sub.b = 8'h3C; sub.bin = 1'b0;
        dones = 0; first = 0; second = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (sub.done) begin
                dones++;
                if (first == 0) first = c; else second = c;
                if (first == c) chk("held_first_diff", sub.diff, 8'h1E);
            end
            if (c == 1) begin sub.a = 8'h00; sub.b = 8'h01; end
            if (c == W + 2) chk("held_gap_idle", sub.busy, 1'b0);
            if (c == W + 3) chk("held_reaccept", sub.busy, 1'b1);
            if (c == 2 * W + 3) sub.start = 1'b0;
        end
        chk("held_dones", dones, 2);
        chk("held_first", first, W + 1);
        chk("held_second", second, 2 * W + 3);
        chk("held_result", {sub.bout, sub.diff}, 9'h1FF);

        // reset during RUN aborts without a done pulse
        @(negedge clk);
        sub.start = 1'b1; sub.a = 8'h5A; sub.b = 8'h3C; sub.bin = 1'b0;
        @(negedge clk);
        sub.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outputs", {sub.busy, sub.done, sub.bout, sub.diff}, '0);
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (sub.done || sub.busy) dones++;
        end
        chk("rst_no_done", dones, 0);
        run_op(8'hFF, 8'h0F, 1'b0);
        chk("after_rst", {sub.bout, sub.diff}, 9'h0F0);

        for (int i = 0; i < 1000; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            run_op(ra, rb, rbin);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
